// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_stage
// Purpose  : Registered RV32I immediate decoder. Decodes I/S/B/U/J immediates,
//            sign-extends to XLEN, classifies the format, precomputes the
//            next-PC candidate and holds the result in a valid/ready stage.
// Revision : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN         = 32,
    parameter bit SHIFT_BRANCH = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic [XLEN-1:0]  target_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [XLEN-1:0]  c_PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Raw byte offsets of the control-transfer formats (bit 0 always zero)
    logic [12:0]     w_b_off;
    logic [20:0]     w_j_off;
    logic [XLEN-1:0] w_i_sext;
    logic [XLEN-1:0] w_s_sext;
    logic [XLEN-1:0] w_u_sext;
    logic [XLEN-1:0] w_b_sext;
    logic [XLEN-1:0] w_j_sext;
    logic [XLEN-1:0] w_b_imm;
    logic [XLEN-1:0] w_j_imm;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_off;
    logic [XLEN-1:0] w_target;
    logic [2:0]      w_fmt;
    logic            w_is_cf;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_fmt;
    logic [XLEN-1:0] r_target;
    logic [CNT_W-1:0] r_cnt;

    assign w_b_off  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_j_off  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    assign w_i_sext = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign w_s_sext = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_b_sext = {{(XLEN-13){instr_i[31]}}, w_b_off};
    assign w_j_sext = {{(XLEN-21){instr_i[31]}}, w_j_off};

    // U immediate fills the low 32 bits; only a wider datapath needs extension
    generate
        if (XLEN > 32) begin : g_u_wide
            assign w_u_sext = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
        end else begin : g_u_narrow
            assign w_u_sext = {instr_i[31:12], 12'b0};
        end
    endgenerate

    // Branch/jump immediate is either the byte offset or the half-word offset
    generate
        if (SHIFT_BRANCH) begin : g_byte_offset
            assign w_b_imm = w_b_sext;
            assign w_j_imm = w_j_sext;
        end else begin : g_half_offset
            assign w_b_imm = {{(XLEN-12){instr_i[31]}}, w_b_off[12:1]};
            assign w_j_imm = {{(XLEN-20){instr_i[31]}}, w_j_off[20:1]};
        end
    endgenerate

    // Opcode classification and immediate selection
    always_comb begin
        w_fmt   = c_FMT_ILL;
        w_imm   = '0;
        w_is_cf = 1'b0;
        w_off   = w_b_sext;
        case (instr_i[6:0])
            c_OP_IMM, c_OP_LOAD, c_OP_JALR: begin
                w_fmt = c_FMT_I;
                w_imm = w_i_sext;
            end
            c_OP_STORE: begin
                w_fmt = c_FMT_S;
                w_imm = w_s_sext;
            end
            c_OP_BRANCH: begin
                w_fmt   = c_FMT_B;
                w_imm   = w_b_imm;
                w_is_cf = 1'b1;
                w_off   = w_b_sext;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_fmt = c_FMT_U;
                w_imm = w_u_sext;
            end
            c_OP_JAL: begin
                w_fmt   = c_FMT_J;
                w_imm   = w_j_imm;
                w_is_cf = 1'b1;
                w_off   = w_j_sext;
            end
            c_OP_REG: begin
                w_fmt = c_FMT_R;
            end
            default: begin
                w_fmt = c_FMT_ILL;
            end
        endcase
    end

    // Target always uses the byte offset; wrap-around is intentional
    assign w_target   = pc_i + (w_is_cf ? w_off : c_PC_STEP);

    assign in_ready_o = !r_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o && !flush_i;

    // Pipeline register: flush beats accept, accept beats pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_imm    <= '0;
            r_fmt    <= c_FMT_R;
            r_target <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (out_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_imm    <= w_imm;
                r_fmt    <= w_fmt;
                r_target <= w_target;
            end
        end
    end

    // Saturating count of accepted illegal opcodes; flush never reaches it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept && (w_fmt == c_FMT_ILL) && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid_o   = r_valid;
    assign imm_o         = r_imm;
    assign fmt_o         = r_fmt;
    assign target_o      = r_target;
    assign illegal_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_decode_stage
// Purpose  : Self-checking bench for imm_decode_stage. Three instances share
//            stimulus: (32, byte offset, 8-bit cnt), (32, half offset, 2-bit
//            cnt) and (64, byte offset, 8-bit cnt).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

    logic        clk;
    logic        rst_i;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] pc_in;

    logic        in_ready_a, in_ready_b, in_ready_w;
    logic        valid_a, valid_b, valid_w;
    logic [31:0] imm_a, imm_b, tgt_a, tgt_b;
    logic [63:0] imm_w, tgt_w;
    logic [2:0]  fmt_a, fmt_b, fmt_w;
    logic [7:0]  cnt_a, cnt_w;
    logic [1:0]  cnt_b;

    int n_pass  = 0;
    int n_total = 0;

    // Model configuration per instance
    int XL[3] = '{32, 32, 64};
    int SH[3] = '{1, 0, 1};
    int CW[3] = '{8, 2, 8};

    // Behavioural model state
    bit          m_valid;
    logic [63:0] m_imm[3];
    logic [63:0] m_tgt[3];
    logic [2:0]  m_fmt[3];
    int          m_cnt[3];

    imm_decode_stage #(.XLEN(32), .SHIFT_BRANCH(1'b1), .CNT_W(8)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_a), .instr_i(instr), .pc_i(pc_in[31:0]),
        .out_valid_o(valid_a), .out_ready_i(out_ready), .imm_o(imm_a),
        .fmt_o(fmt_a), .target_o(tgt_a), .illegal_cnt_o(cnt_a));

    imm_decode_stage #(.XLEN(32), .SHIFT_BRANCH(1'b0), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_b), .instr_i(instr), .pc_i(pc_in[31:0]),
        .out_valid_o(valid_b), .out_ready_i(out_ready), .imm_o(imm_b),
        .fmt_o(fmt_b), .target_o(tgt_b), .illegal_cnt_o(cnt_b));

    imm_decode_stage #(.XLEN(64), .SHIFT_BRANCH(1'b1), .CNT_W(8)) dut_w (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_w), .instr_i(instr), .pc_i(pc_in),
        .out_valid_o(valid_w), .out_ready_i(out_ready), .imm_o(imm_w),
        .fmt_o(fmt_w), .target_o(tgt_w), .illegal_cnt_o(cnt_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [63:0] mask(input longint v, input int xl);
        logic [63:0] r;
        r = v;
        if (xl == 32) r[63:32] = 32'h0;
        return r;
    endfunction

    // Reference decode written from the field-placement rules with arithmetic
    task automatic ref_dec(input logic [31:0] ins, input logic [63:0] pc, input int xl,
                           input int sh, output logic [63:0] imm, output logic [2:0] fmt,
                           output logic [63:0] tgt);
        longint v, off;
        bit cf;
        v = 0; off = 0; cf = 0; fmt = 3'd7;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                fmt = 3'd1;
                v = longint'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            7'h23: begin
                fmt = 3'd2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            7'h63: begin
                fmt = 3'd3; cf = 1;
                off = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) off -= 8192;
                v = (sh != 0) ? off : off / 2;
            end
            7'h37, 7'h17: begin
                fmt = 3'd4;
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v -= 64'h1_0000_0000;
            end
            7'h6F: begin
                fmt = 3'd5; cf = 1;
                off = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                    + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) off -= 2097152;
                v = (sh != 0) ? off : off / 2;
            end
            7'h33: fmt = 3'd0;
            default: fmt = 3'd7;
        endcase
        imm = mask(v, xl);
        tgt = mask(longint'(pc) + (cf ? off : 4), xl);
    endtask

    task automatic chk_inst(input int i, input logic v, input logic [63:0] imm,
                            input logic [2:0] f, input logic [63:0] t, input int c);
        chk($sformatf("valid[%0d]", i), v, m_valid);
        if (m_valid) begin
            chk($sformatf("imm[%0d]", i), imm, m_imm[i]);
            chk($sformatf("fmt[%0d]", i), f, m_fmt[i]);
            chk($sformatf("target[%0d]", i), t, m_tgt[i]);
        end
        chk($sformatf("cnt[%0d]", i), c, m_cnt[i]);
    endtask

    task automatic compare_all();
        chk_inst(0, valid_a, {32'h0, imm_a}, fmt_a, {32'h0, tgt_a}, int'(cnt_a));
        chk_inst(1, valid_b, {32'h0, imm_b}, fmt_b, {32'h0, tgt_b}, int'(cnt_b));
        chk_inst(2, valid_w, imm_w, fmt_w, tgt_w, int'(cnt_w));
    endtask

    // One clock of stimulus with model update and full comparison afterwards
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                         input bit rdy, input bit fl);
        logic [63:0] ni[3];
        logic [63:0] nt[3];
        logic [2:0]  nf[3];
        bit          rdy_m, acc;
        in_valid = v; instr = ins; pc_in = pc; out_ready = rdy; flush = fl;
        #1;
        rdy_m = !m_valid || rdy;
        chk("in_ready[0]", in_ready_a, rdy_m);
        chk("in_ready[1]", in_ready_b, rdy_m);
        chk("in_ready[2]", in_ready_w, rdy_m);
        acc = v && rdy_m && !fl;
        for (int i = 0; i < 3; i++) ref_dec(ins, pc, XL[i], SH[i], ni[i], nf[i], nt[i]);
        @(posedge clk);
        #1;
        if (fl) m_valid = 0;
        else if (acc) m_valid = 1;
        else if (rdy) m_valid = 0;
        if (acc) begin
            for (int i = 0; i < 3; i++) begin
                m_imm[i] = ni[i]; m_fmt[i] = nf[i]; m_tgt[i] = nt[i];
                if (nf[i] == 3'd7 && m_cnt[i] < (1 << CW[i]) - 1) m_cnt[i]++;
            end
        end
        compare_all();
    endtask

    task automatic do_reset();
        rst_i = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = 32'h0; pc_in = 64'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_valid = 0;
        for (int i = 0; i < 3; i++) begin
            m_imm[i] = 0; m_tgt[i] = 0; m_fmt[i] = 0; m_cnt[i] = 0;
        end
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_imm", imm_w, 64'h0);
        chk("rst_fmt", fmt_a, 3'd0);
        chk("rst_target", tgt_w, 64'h0);
        chk("rst_cnt", cnt_a, 8'h0);
        rst_i = 1'b0;
        #1;
        chk("rst_in_ready", in_ready_a, 1'b1);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] imm_a;
        logic [31:0] imm_b;
        logic [2:0]  fmt;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[11];
    logic [6:0] ops[11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'h0000_0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h0000_0104};
        vecs[1]  = '{32'hFE000EE3, 32'h0000_0200, 32'hFFFFFFFC, 32'hFFFFFFFE, 3'd3, 32'h0000_01FC};
        vecs[2]  = '{32'h0080006F, 32'hFFFF_FFFC, 32'h00000008, 32'h00000004, 3'd5, 32'h0000_0004};
        vecs[3]  = '{32'h123450B7, 32'h0000_0000, 32'h12345000, 32'h12345000, 3'd4, 32'h0000_0004};
        vecs[4]  = '{32'hFE112E23, 32'h0000_0300, 32'hFFFFFFFC, 32'hFFFFFFFC, 3'd2, 32'h0000_0304};
        vecs[5]  = '{32'h002081B3, 32'h0000_0400, 32'h00000000, 32'h00000000, 3'd0, 32'h0000_0404};
        vecs[6]  = '{32'h0000007F, 32'h0000_0500, 32'h00000000, 32'h00000000, 3'd7, 32'h0000_0504};
        vecs[7]  = '{32'hFFFFF097, 32'h0000_0010, 32'hFFFFF000, 32'hFFFFF000, 3'd4, 32'h0000_0014};
        vecs[8]  = '{32'h7FF080E7, 32'h0000_0020, 32'h000007FF, 32'h000007FF, 3'd1, 32'h0000_0024};
        vecs[9]  = '{32'h00209463, 32'h0000_1000, 32'h00000008, 32'h00000004, 3'd3, 32'h0000_1008};
        vecs[10] = '{32'h00412083, 32'h0000_0040, 32'h00000004, 32'h00000004, 3'd1, 32'h0000_0044};

        do_reset();

        // Directed table
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, vecs[i].ins, {32'h0, vecs[i].pc}, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_imm_a", i), imm_a, vecs[i].imm_a);
            chk($sformatf("tbl%0d_imm_b", i), imm_b, vecs[i].imm_b);
            chk($sformatf("tbl%0d_fmt", i), fmt_a, vecs[i].fmt);
            chk($sformatf("tbl%0d_tgt_a", i), tgt_a, vecs[i].tgt);
            chk($sformatf("tbl%0d_tgt_b", i), tgt_b, vecs[i].tgt);
            if (i == 0) chk("x64_addi_imm", imm_w, 64'hFFFF_FFFF_FFFF_FFFF);
        end

        // Backpressure: LUI held while ADDI waits three cycles
        cycle(1'b1, 32'h123450B7, 64'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'hFFF00093, 64'h100, 1'b0, 1'b0);
            chk("stall_in_ready", in_ready_a, 1'b0);
            chk("stall_imm", imm_a, 32'h12345000);
            chk("stall_fmt", fmt_a, 3'd4);
            chk("stall_tgt", tgt_a, 32'h4);
        end
        cycle(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0);
        chk("release_valid", valid_a, 1'b1);
        chk("release_imm", imm_a, 32'hFFFFFFFF);
        chk("release_tgt", tgt_a, 32'h104);

        // Flush while holding an entry, with an illegal instruction offered
        cycle(1'b1, 32'hFFF00093, 64'h100, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000007F, 64'h200, 1'b1, 1'b1);
        chk("flush_valid", valid_a, 1'b0);
        chk("flush_cnt", cnt_a, 8'd1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("flush_dropped", valid_a, 1'b0);

        // Counter and saturation
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
        chk("cnt3_a", cnt_a, 8'd3);
        chk("cnt3_fmt", fmt_a, 3'd7);
        for (int k = 0; k < 2; k++) cycle(1'b1, 32'hABCDE07F, 64'h0, 1'b1, 1'b0);
        chk("cnt5_a", cnt_a, 8'd5);
        chk("cnt5_sat_b", cnt_b, 2'd3);

        // Asynchronous reset in the middle of a stall
        cycle(1'b1, 32'hFE000EE3, 64'h200, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFF00093, 64'h100, 1'b0, 1'b0);
        #1;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", valid_a, 1'b0);
        chk("arst_imm", imm_a, 32'h0);
        chk("arst_fmt", fmt_a, 3'd0);
        chk("arst_tgt", tgt_w, 64'h0);
        chk("arst_cnt", cnt_a, 8'h0);
        #1;
        rst_i = 1'b0;
        m_valid = 0;
        for (int i = 0; i < 3; i++) begin
            m_imm[i] = 0; m_tgt[i] = 0; m_fmt[i] = 0; m_cnt[i] = 0;
        end
        #1;
        chk("arst_in_ready", in_ready_a, 1'b1);

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ri;
            logic [63:0] rp;
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 10)];
            rp = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rp = {32'h0, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
            cycle(($urandom_range(0, 3) != 0), ri, rp,
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate decoder for the pipelined CPU. It decodes every RV32I immediate format (I, S, B, U, J) from a fetched instruction, sign-extends the result to XLEN, classifies the format and precomputes the control-transfer target. Results are held in a valid/ready pipeline register with flush support. It sits at the IF/ID boundary and feeds the ID stage, branch unit and ALU operand mux.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64. Applies to the immediate, the PC and the target.
- SHIFT_BRANCH, 1:
  - 1: the B/J immediate is a byte offset with bit 0 = 0.
  - 0: the B/J immediate is the half-word offset {sign, imm[12:1]} or {sign, imm[20:1]}, for datapaths that shift in the adder.
- CNT_W, 8: width of the illegal-opcode counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discards the held entry and any same-cycle input.
- in_valid_i  in  1  instr_i/pc_i valid.
- in_ready_o  out  1  stage can accept.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  PC of instr_i.
- out_valid_o  out  1  registered outputs valid.
- out_ready_i  in  1  consumer accepts.
- imm_o  out  XLEN  sign-extended immediate.
- fmt_o  out  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- target_o  out  XLEN  precomputed next-PC candidate.
- illegal_cnt_o  out  CNT_W  saturating count of accepted illegal opcodes.

## Operation
- Opcode map, on instr_i[6:0]:
  - I format: 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR). imm = sext(instr[31:20]).
  - S format: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B format: 1100011. offset = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U format: 0110111, 0010111. imm = sext({instr[31:12], 12'b0}).
  - J format: 1101111. offset = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R format: 0110011. imm = 0, fmt 0.
  - Any other opcode: imm = 0, fmt 7.
- B/J immediate: with SHIFT_BRANCH=1, imm = sext(offset); with SHIFT_BRANCH=0, imm = sext(offset[12:1]) for B and sext(offset[20:1]) for J.
- target_o:
  - B or J: pc_i + sext(offset), always the byte offset regardless of SHIFT_BRANCH.
  - All other formats: pc_i + 4.
  - Arithmetic is modulo 2^XLEN; wrap-around is silent.
- Sign extension always takes instr[31] and fills up to XLEN.
- Decode and add are combinational on the inputs; the results are captured into the output register on accept.
- illegal_cnt_o increments by 1 on each accepted fmt-7 instruction, saturates at all-ones, and is not affected by flush_i.

## Timing
- Single register stage; latency 1 cycle from accept to out_valid_o.
- in_ready_o = !out_valid_o || out_ready_i, combinational. There is no skid buffer, so full throughput is 1 instruction per cycle.
- Accept = in_valid_i && in_ready_o && !flush_i. On accept, the registers load and out_valid_o = 1 next cycle.
- Output pop: out_valid_o && out_ready_i with no accept clears out_valid_o next cycle. Pop and accept in the same cycle leaves out_valid_o = 1 holding the new data.
- Stall: while out_valid_o && !out_ready_i, imm_o, fmt_o and target_o hold stable and in_ready_o = 0.
- flush_i has top priority:
  - out_valid_o = 0 next cycle and the input is dropped.
  - The data registers may keep their stale values.
  - The counter does not increment.
- Reset, asynchronous:
  - out_valid_o = 0, imm_o = 0, fmt_o = 0, target_o = 0, illegal_cnt_o = 0.
  - in_ready_o = 1 as soon as reset releases.
  - Reset asserted mid-stall clears the held entry immediately, without waiting for a clock edge.

## Test plan
- ADDI 0xFFF00093 at pc 0x100, out_ready_i = 1: one cycle later out_valid_o = 1, imm_o = 0xFFFFFFFF, fmt_o = 1, target_o = 0x104.
- BEQ 0xFE000EE3 at pc 0x200:
  - SHIFT_BRANCH=1: imm_o = 0xFFFFFFFC, fmt_o = 3, target_o = 0x1FC.
  - SHIFT_BRANCH=0: imm_o = 0xFFFFFFFE, target_o = 0x1FC.
- JAL 0x0080006F at pc 0xFFFFFFFC (XLEN = 32): imm_o = 0x8, fmt_o = 5, target_o = 0x4 (wrap-around). LUI 0x123450B7: imm_o = 0x12345000, fmt_o = 4.
- Backpressure: hold out_ready_i = 0 for 3 cycles with a second instruction pending:
  - in_ready_o = 0 and outputs stable throughout.
  - On release, the first entry pops and the second loads in the same cycle, so out_valid_o stays 1.
- Flush while holding an entry and driving a new valid input: out_valid_o = 0 next cycle, the input is not captured and illegal_cnt_o is unchanged. Assert rst_i mid-stall: all outputs read 0 immediately.
- Counter:
  - 3 accepted opcode 0x7F instructions give illegal_cnt_o = 3 and fmt_o = 7.
  - With CNT_W = 2, 5 illegal accepts leave the count at 3.
  - XLEN = 64: ADDI 0xFFF00093 gives imm_o = 0xFFFFFFFFFFFFFFFF.
